apb_rr_master: RTL and testbench

// - Shares one APB3/APB4 slave port between N_REQ local requesters. Requesters use a simple req/ack interface.
// - Round-robin arbitration; the granted request is sequenced through the APB SETUP and ACCESS phases.
// - Sits between internal controllers and APB register slaves such as APB_template_slave.

---
 rtl/apb_rr_master.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_apb_rr_master.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_rr_master.sv
`default_nettype none
// ============================================================================
//  Module      : apb_rr_master
//  Description : Round-robin APB3/APB4 master. Shares one APB slave port
//                between N_REQ local requesters that use a req/ack handshake.
//                A granted request is walked through the APB SETUP and ACCESS
//                phases; completion returns a one-cycle, one-hot ack together
//                with read data and an error flag.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    N_REQ           number of requesters (>= 2)
//    DATA_WIDTH      APB data width (multiple of 8)
//    PPROT_VAL       constant driven on pprot
//    TIMEOUT_CYCLES  ACCESS-phase cycles before abort (APB_TIMEOUT_EN only)
//
//  Ports
//    pclk, presetn       clock, synchronous active-low reset
//    req                 request per requester, held until ack
//    req_addr            packed 32-bit byte addresses, slice i = requester i
//    req_write           1 = write, 0 = read
//    req_wdata/req_strb  packed write data and byte strobes
//    ack                 one-hot, one-cycle completion pulse
//    rsp_rdata/rsp_err   read data / error, valid while ack != 0, else 0
//    paddr..pstrb        registered APB request outputs
//    pready/prdata/pslverr  APB slave response, sampled in ACCESS only
//
//  Build option
//    APB_TIMEOUT_EN  when defined, an ACCESS phase that sees no pready for
//                    TIMEOUT_CYCLES cycles completes with rsp_err = 1.
// ============================================================================
module apb_rr_master #(
    parameter int         N_REQ          = 4,
    parameter int         DATA_WIDTH     = 32,
    parameter logic [2:0] PPROT_VAL      = 3'b000,
    parameter int         TIMEOUT_CYCLES = 16
) (
    input  logic                            pclk,
    input  logic                            presetn,
    // local requesters
    input  logic [N_REQ-1:0]                req,
    input  logic [N_REQ*32-1:0]             req_addr,
    input  logic [N_REQ-1:0]                req_write,
    input  logic [N_REQ*DATA_WIDTH-1:0]     req_wdata,
    input  logic [N_REQ*DATA_WIDTH/8-1:0]   req_strb,
    output logic [N_REQ-1:0]                ack,
    output logic [DATA_WIDTH-1:0]           rsp_rdata,
    output logic                            rsp_err,
    // APB master
    output logic [31:0]                     paddr,
    output logic [2:0]                      pprot,
    output logic                            psel,
    output logic                            penable,
    output logic                            pwrite,
    output logic [DATA_WIDTH-1:0]           pwdata,
    output logic [DATA_WIDTH/8-1:0]         pstrb,
    input  logic                            pready,
    input  logic [DATA_WIDTH-1:0]           prdata,
    input  logic                            pslverr
);

    localparam int c_STRB_W = DATA_WIDTH / 8;
    localparam int c_PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t                 r_state;
    logic [c_PTR_W-1:0]     r_ptr;
    logic [c_PTR_W-1:0]     r_grant;
    logic [31:0]            r_paddr;
    logic                   r_psel;
    logic                   r_penable;
    logic                   r_pwrite;
    logic [DATA_WIDTH-1:0]  r_pwdata;
    logic [c_STRB_W-1:0]    r_pstrb;
    logic [N_REQ-1:0]       r_ack;
    logic [DATA_WIDTH-1:0]  r_rdata;
    logic                   r_err;

    // Next-state values
    state_t                 w_state;
    logic [c_PTR_W-1:0]     w_ptr;
    logic [c_PTR_W-1:0]     w_grant;
    logic [31:0]            w_paddr;
    logic                   w_psel;
    logic                   w_penable;
    logic                   w_pwrite;
    logic [DATA_WIDTH-1:0]  w_pwdata;
    logic [c_STRB_W-1:0]    w_pstrb;
    logic [N_REQ-1:0]       w_ack;
    logic [DATA_WIDTH-1:0]  w_rdata;
    logic                   w_err;

`ifdef APB_TIMEOUT_EN
    localparam int c_TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_TMO_W-1:0]     r_tmo;
    logic [c_TMO_W-1:0]     w_tmo;
    logic                   w_tmo_hit;
`else
    logic                   w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT_CYCLES > 0);
`endif

    // ------------------------------------------------------------------
    // Unpack the per-requester buses into arrays
    // ------------------------------------------------------------------
    logic [31:0]            w_addr_a  [N_REQ];
    logic [DATA_WIDTH-1:0]  w_wdata_a [N_REQ];
    logic [c_STRB_W-1:0]    w_strb_a  [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign w_addr_a[i]  = req_addr[i*32 +: 32];
        assign w_wdata_a[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        assign w_strb_a[i]  = req_strb[i*c_STRB_W +: c_STRB_W];
    end

    // ------------------------------------------------------------------
    // Round-robin pick: first eligible requester at or after r_ptr.
    // The requester being acked this cycle still has req high (it drops
    // it in response to ack), so it is masked out to avoid a re-grant.
    // ------------------------------------------------------------------
    logic [N_REQ-1:0]       w_elig;
    logic                   w_found;
    logic [c_PTR_W-1:0]     w_pick;

    assign w_elig = req & ~r_ack;

    always_comb begin
        int v_idx;
        v_idx   = 0;
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            v_idx = int'(r_ptr) + k;
            if (v_idx >= N_REQ) begin
                v_idx = v_idx - N_REQ;
            end
            if (!w_found && w_elig[c_PTR_W'(v_idx)]) begin
                w_found = 1'b1;
                w_pick  = c_PTR_W'(v_idx);
            end
        end
    end

    // Pointer following the current grant, wrapping N_REQ-1 -> 0
    logic [c_PTR_W-1:0]     w_ptr_next;
    assign w_ptr_next = (r_grant == c_PTR_W'(N_REQ - 1)) ? '0
                                                         : r_grant + c_PTR_W'(1);

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state   = r_state;
        w_ptr     = r_ptr;
        w_grant   = r_grant;
        w_paddr   = r_paddr;
        w_psel    = r_psel;
        w_penable = r_penable;
        w_pwrite  = r_pwrite;
        w_pwdata  = r_pwdata;
        w_pstrb   = r_pstrb;
        // ack and response fields are single-cycle pulses
        w_ack     = '0;
        w_rdata   = '0;
        w_err     = 1'b0;
`ifdef APB_TIMEOUT_EN
        w_tmo     = r_tmo;
        w_tmo_hit = 1'b0;
`endif

        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_grant   = w_pick;
                    w_paddr   = w_addr_a[w_pick];
                    w_pwrite  = req_write[w_pick];
                    w_pwdata  = w_wdata_a[w_pick];
                    w_pstrb   = w_strb_a[w_pick];
                    w_psel    = 1'b1;
                    w_penable = 1'b0;
                    w_state   = S_SETUP;
                end
            end

            S_SETUP: begin
                w_penable = 1'b1;
                w_state   = S_ACCESS;
`ifdef APB_TIMEOUT_EN
                w_tmo     = '0;
`endif
            end

            S_ACCESS: begin
                if (pready) begin
                    w_psel           = 1'b0;
                    w_penable        = 1'b0;
                    w_ack[r_grant]   = 1'b1;
                    w_rdata          = r_pwrite ? '0 : prdata;
                    w_err            = pslverr;
                    w_ptr            = w_ptr_next;
                    w_state          = S_IDLE;
                end
`ifdef APB_TIMEOUT_EN
                else begin
                    // Counter reaching TIMEOUT_CYCLES on this cycle ends the
                    // transfer as an error completion with no read data.
                    w_tmo     = r_tmo + c_TMO_W'(1);
                    w_tmo_hit = (w_tmo == c_TMO_W'(TIMEOUT_CYCLES));
                    if (w_tmo_hit) begin
                        w_psel         = 1'b0;
                        w_penable      = 1'b0;
                        w_ack[r_grant] = 1'b1;
                        w_rdata        = '0;
                        w_err          = 1'b1;
                        w_ptr          = w_ptr_next;
                        w_state        = S_IDLE;
                    end
                end
`endif
            end

            default: begin
                w_psel    = 1'b0;
                w_penable = 1'b0;
                w_state   = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register; reset aborts any transfer without an ack
    // ------------------------------------------------------------------
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_grant   <= '0;
            r_paddr   <= '0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_pwdata  <= '0;
            r_pstrb   <= '0;
            r_ack     <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_ptr     <= w_ptr;
            r_grant   <= w_grant;
            r_paddr   <= w_paddr;
            r_psel    <= w_psel;
            r_penable <= w_penable;
            r_pwrite  <= w_pwrite;
            r_pwdata  <= w_pwdata;
            r_pstrb   <= w_pstrb;
            r_ack     <= w_ack;
            r_rdata   <= w_rdata;
            r_err     <= w_err;
        end
    end

`ifdef APB_TIMEOUT_EN
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            r_tmo <= '0;
        end else begin
            r_tmo <= w_tmo;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign paddr     = r_paddr;
    assign pprot     = PPROT_VAL;
    assign psel      = r_psel;
    assign penable   = r_penable;
    assign pwrite    = r_pwrite;
    assign pwdata    = r_pwdata;
    assign pstrb     = r_pstrb;
    assign ack       = r_ack;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_apb_rr_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_rr_master
//  Description : Self-checking bench for apb_rr_master with a small APB
//                register slave (BASE 0x08, 8 regs reset to their index,
//                writes accumulate under strobes, pready = penable unless
//                wait states are requested).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_apb_rr_master;

    localparam int N_REQ = 4;
    localparam int DW    = 32;

    logic                 pclk = 1'b0;
    logic                 presetn;
    logic [N_REQ-1:0]     req;
    logic [N_REQ*32-1:0]  req_addr;
    logic [N_REQ-1:0]     req_write;
    logic [N_REQ*DW-1:0]  req_wdata;
    logic [N_REQ*4-1:0]   req_strb;
    logic [N_REQ-1:0]     ack;
    logic [DW-1:0]        rsp_rdata;
    logic                 rsp_err;
    logic [31:0]          paddr;
    logic [2:0]           pprot;
    logic                 psel;
    logic                 penable;
    logic                 pwrite;
    logic [DW-1:0]        pwdata;
    logic [3:0]           pstrb;
    logic                 pready;
    logic [DW-1:0]        prdata;
    logic                 pslverr;

    int                   wait_cfg;
    bit                   stuck;

    always #5 pclk = ~pclk;

    apb_rr_master #(
        .N_REQ          (N_REQ),
        .DATA_WIDTH     (DW),
        .PPROT_VAL      (3'b000),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .pclk      (pclk),
        .presetn   (presetn),
        .req       (req),
        .req_addr  (req_addr),
        .req_write (req_write),
        .req_wdata (req_wdata),
        .req_strb  (req_strb),
        .ack       (ack),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .paddr     (paddr),
        .pprot     (pprot),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .pwdata    (pwdata),
        .pstrb     (pstrb),
        .pready    (pready),
        .prdata    (prdata),
        .pslverr   (pslverr)
    );

    // ------------------------------------------------------------------
    // APB register slave model
    // ------------------------------------------------------------------
    logic [31:0] regs [8];
    logic [31:0] off;
    logic [2:0]  ridx;
    logic        in_rng;
    logic [3:0]  wcnt;
    logic [31:0] wmask;

    assign off    = paddr - 32'h8;
    assign ridx   = off[4:2];
    assign in_rng = (paddr >= 32'h8) && (paddr < 32'h28);

    always_comb begin
        wmask = '0;
        for (int b = 0; b < 4; b++) wmask[8*b +: 8] = {8{pstrb[b]}};
    end

    assign pready  = penable && (wcnt == 4'd0) && !stuck;
    assign prdata  = (psel && !pwrite && in_rng) ? regs[ridx] : 32'h0;
    assign pslverr = psel && penable && !in_rng;

    always @(posedge pclk) begin
        if (!presetn) begin
            for (int i = 0; i < 8; i++) regs[i] <= 32'(i);
            wcnt <= 4'd0;
        end else begin
            if (psel && !penable) wcnt <= 4'(wait_cfg);
            else if (psel && penable && wcnt != 4'd0) wcnt <= wcnt - 4'd1;
            if (psel && penable && pready && pwrite && in_rng)
                regs[ridx] <= regs[ridx] + (pwdata & wmask);
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        int          id;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        int          id;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] rdata;
        bit          err;
    } vec_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   ack_cyc[N_REQ];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: sample at the falling edge, score any ack, and let the
    // acked requester drop its req.
    task automatic tick();
        exp_t e;
        @(negedge pclk);
        cyc++;
        if (ack != '0) begin
            if (sbq.size() == 0) begin
                chk("unexpected_ack", 64'(ack), 64'd0);
            end else begin
                e = sbq.pop_front();
                chk("ack_onehot", 64'(ack), 64'd1 << e.id);
                chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                chk("rsp_err", 64'(rsp_err), 64'(e.err));
                ack_cyc[e.id] = cyc;
            end
            req = req & ~ack;
        end else begin
            chk("idle_rsp_zero", 64'({rsp_rdata, rsp_err}), 64'd0);
        end
    endtask

    task automatic issue(input int id, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s,
                         input logic [31:0] er, input bit ee);
        exp_t e;
        req_addr[id*32 +: 32]  = a;
        req_write[id]          = wr;
        req_wdata[id*DW +: DW] = d;
        req_strb[id*4 +: 4]    = s;
        req[id]                = 1'b1;
        e.id    = id;
        e.rdata = er;
        e.err   = ee;
        sbq.push_back(e);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sbq.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (sbq.size() != 0) begin
            chk("drain_timeout", 64'(sbq.size()), 64'd0);
            sbq.delete();
            req = '0;
        end
        tick();
    endtask

    task automatic do_reset(input int n);
        presetn = 1'b0;
        req     = '0;
        repeat (n) tick();
        presetn = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    vec_t vt[9];
    int   ntmo;

    initial begin
        presetn   = 1'b0;
        req       = '0;
        req_addr  = '0;
        req_write = '0;
        req_wdata = '0;
        req_strb  = '0;
        wait_cfg  = 0;
        stuck     = 1'b0;
        ntmo      = 0;
        for (int i = 0; i < N_REQ; i++) ack_cyc[i] = 0;

        // Reset state
        repeat (3) tick();
        chk("rst_psel_penable", 64'({psel, penable, pwrite}), 64'd0);
        chk("rst_paddr", 64'(paddr), 64'd0);
        chk("rst_pwdata", 64'(pwdata), 64'd0);
        chk("rst_pstrb", 64'(pstrb), 64'd0);
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_pprot", 64'(pprot), 64'd0);
        presetn = 1'b1;
        tick();

        // Single read: latency 1/2/3 cycles
        issue(0, 1'b0, 32'h10, 32'h0, 4'hF, 32'd2, 1'b0);
        tick();
        chk("lat_c1_psel", 64'({psel, penable}), 64'b10);
        chk("lat_c1_paddr", 64'(paddr), 64'h10);
        tick();
        chk("lat_c2_penable", 64'({psel, penable}), 64'b11);
        tick();
        chk("lat_c3_ack", 64'(ack), 64'b0001);
        drain(10);

        // Contention from pointer 0
        do_reset(2);
        issue(0, 1'b0, 32'h08, 32'h0, 4'hF, 32'd0, 1'b0);
        issue(1, 1'b0, 32'h0C, 32'h0, 4'hF, 32'd1, 1'b0);
        issue(2, 1'b0, 32'h10, 32'h0, 4'hF, 32'd2, 1'b0);
        issue(3, 1'b0, 32'h14, 32'h0, 4'hF, 32'd3, 1'b0);
        drain(30);
        for (int i = 0; i < 3; i++)
            chk("rr_spacing", 64'(ack_cyc[i+1] - ack_cyc[i]), 64'd3);
        // pointer wrapped to 0: req 0 before req 2
        issue(0, 1'b0, 32'h08, 32'h0, 4'hF, 32'd0, 1'b0);
        issue(2, 1'b0, 32'h10, 32'h0, 4'hF, 32'd2, 1'b0);
        drain(20);

        // Table of single transfers
        vt[0] = '{1, 1'b1, 32'h0C, 32'd5,        4'hF,    32'd0,    1'b0};
        vt[1] = '{1, 1'b0, 32'h0C, 32'd0,        4'hF,    32'd6,    1'b0};
        vt[2] = '{3, 1'b0, 32'h08, 32'd0,        4'hF,    32'd0,    1'b0};
        vt[3] = '{0, 1'b1, 32'h24, 32'h10,       4'hF,    32'd0,    1'b0};
        vt[4] = '{2, 1'b0, 32'h24, 32'd0,        4'hF,    32'h17,   1'b0};
        vt[5] = '{3, 1'b1, 32'h18, 32'hABCD0102, 4'b0001, 32'd0,    1'b0};
        vt[6] = '{0, 1'b0, 32'h18, 32'd0,        4'hF,    32'd6,    1'b0};
        vt[7] = '{2, 1'b1, 32'h28, 32'd1,        4'hF,    32'd0,    1'b1};
        vt[8] = '{1, 1'b0, 32'h04, 32'd0,        4'hF,    32'd0,    1'b1};
        for (int i = 0; i < 9; i++) begin
            issue(vt[i].id, vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].strb,
                  vt[i].rdata, vt[i].err);
            drain(20);
        end

        // Error completion still advances the pointer (2 -> 3)
        issue(2, 1'b0, 32'h100, 32'h0, 4'hF, 32'd0, 1'b1);
        drain(20);
        issue(3, 1'b0, 32'h14, 32'h0, 4'hF, 32'd3, 1'b0);
        issue(0, 1'b0, 32'h08, 32'h0, 4'hF, 32'd0, 1'b0);
        drain(20);

        // Wait states: 3 stalled cycles, then pready
        wait_cfg = 3;
        issue(1, 1'b1, 32'h1C, 32'h20, 4'hF, 32'd0, 1'b0);
        tick();
        chk("ws_setup", 64'({psel, penable}), 64'b10);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("ws_penable", 64'(penable), 64'd1);
            chk("ws_paddr", 64'(paddr), 64'h1C);
            chk("ws_pwdata", 64'(pwdata), 64'h20);
        end
        tick();
        chk("ws_ack", 64'(ack), 64'b0010);
        chk("ws_bus_idle", 64'({psel, penable}), 64'd0);
        wait_cfg = 0;
        drain(10);
        issue(2, 1'b0, 32'h1C, 32'h0, 4'hF, 32'h25, 1'b0);
        drain(10);

        // Reset during ACCESS: bus drops, no ack, pointer back to 0
        wait_cfg = 5;
        issue(0, 1'b0, 32'h08, 32'h0, 4'hF, 32'd0, 1'b0);
        tick();
        tick();
        chk("rst_mid_access", 64'({psel, penable}), 64'b11);
        presetn = 1'b0;
        req     = '0;
        sbq.delete();
        tick();
        chk("rst_mid_abort", 64'({psel, penable, ack}), 64'd0);
        presetn  = 1'b1;
        wait_cfg = 0;
        repeat (5) tick();
        issue(1, 1'b0, 32'h0C, 32'h0, 4'hF, 32'd1, 1'b0);
        issue(3, 1'b0, 32'h14, 32'h0, 4'hF, 32'd3, 1'b0);
        drain(20);

`ifdef APB_TIMEOUT_EN
        // pready stuck low: error completion after 16 ACCESS cycles
        stuck = 1'b1;
        issue(3, 1'b0, 32'h08, 32'h0, 4'hF, 32'd0, 1'b1);
        tick();
        while (ack == '0 && ntmo < 40) begin
            if (penable) ntmo++;
            tick();
        end
        chk("tmo_access_cycles", 64'(ntmo), 64'd16);
        stuck = 1'b0;
        drain(10);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
